// File: rtl/draw_pkg.sv
// Shared constants for the rectangle draw engine: screen geometry, field
// widths, colour palette and FSM state encoding.
package draw_pkg;
    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;
    localparam int W_BITS   = 7;
    localparam int H_BITS   = 5;
    localparam int X_BITS   = 8;
    localparam int Y_BITS   = 7;

    localparam logic [2:0] BLACK = 3'b000;
    localparam logic [2:0] RED   = 3'b100;
    localparam logic [2:0] GREEN = 3'b010;
    localparam logic [2:0] WHITE = 3'b111;

    typedef enum logic {S_IDLE = 1'b0, S_DRAW = 1'b1} state_t;
endpackage

// File: rtl/rect_draw_engine_if.sv
// Request handshake plus pixel-write bus between datapath, engine and vga_adapter.
interface rect_draw_engine_if;
    import draw_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic [X_BITS-1:0] req_x;
    logic [Y_BITS-1:0] req_y;
    logic [W_BITS-1:0] req_w;
    logic [H_BITS-1:0] req_h;
    logic [2:0]        req_colour;
    logic              req_clear;
    logic [X_BITS-1:0] vga_x;
    logic [Y_BITS-1:0] vga_y;
    logic [2:0]        vga_colour;
    logic              vga_plot;
    logic              busy;
    logic              done;

    modport master (output req_valid, req_x, req_y, req_w, req_h, req_colour, req_clear,
                    input  req_ready, vga_x, vga_y, vga_colour, vga_plot, busy, done);
    modport slave  (input  req_valid, req_x, req_y, req_w, req_h, req_colour, req_clear,
                    output req_ready, vga_x, vga_y, vga_colour, vga_plot, busy, done);
endinterface

// File: rtl/rect_draw_engine_scan.sv
// Row-major 2-D scan counter: cx runs 0..w-1, then wraps and bumps cy.
module rect_scan_counter
    import draw_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              i_start,
    input  logic              i_enable,
    input  logic [X_BITS-1:0] i_w,
    input  logic [Y_BITS-1:0] i_h,
    output logic [X_BITS-1:0] o_cx,
    output logic [Y_BITS-1:0] o_cy,
    output logic              o_last
);
    logic [X_BITS-1:0] r_cx;
    logic [Y_BITS-1:0] r_cy;
    logic              w_row_end;

    assign w_row_end = (r_cx == i_w - X_BITS'(1));
    assign o_last    = w_row_end && (r_cy == i_h - Y_BITS'(1));
    assign o_cx      = r_cx;
    assign o_cy      = r_cy;

    always_ff @(posedge clock) begin
        if (reset || i_start) begin
            r_cx <= '0;
            r_cy <= '0;
        end else if (i_enable) begin
            if (w_row_end) begin
                r_cx <= '0;
                r_cy <= r_cy + Y_BITS'(1);
            end else begin
                r_cx <= r_cx + X_BITS'(1);
            end
        end
    end
endmodule

// File: rtl/rect_draw_engine.sv
// Rectangle fill engine: accepts one rect per handshake and emits one clipped
// pixel write per clock toward vga_adapter.
module rect_draw_engine
    import draw_pkg::*;
(
    input  logic               clock,
    input  logic               reset,
    rect_draw_engine_if.slave  bus
);
    state_t            r_state, w_next;
    logic [X_BITS-1:0] r_bx, r_w, r_vx;
    logic [Y_BITS-1:0] r_by, r_h, r_vy;
    logic [2:0]        r_col, r_vc;
    logic              r_plot, r_done;

    logic [X_BITS-1:0] w_cx;
    logic [Y_BITS-1:0] w_cy;
    logic              w_last, w_accept, w_zero, w_inside;
    logic [X_BITS:0]   w_px;
    logic [Y_BITS:0]   w_py;

    assign w_accept = bus.req_valid && (r_state == S_IDLE);
    assign w_zero   = !bus.req_clear && (bus.req_w == '0 || bus.req_h == '0);
    // One extra bit so off-screen coordinates past 255/127 still clip.
    assign w_px     = {1'b0, r_bx} + {1'b0, w_cx};
    assign w_py     = {1'b0, r_by} + {1'b0, w_cy};
    assign w_inside = (w_px < (X_BITS+1)'(SCREEN_W)) && (w_py < (Y_BITS+1)'(SCREEN_H));

    rect_scan_counter u_scan (
        .clock    (clock),
        .reset    (reset),
        .i_start  (w_accept),
        .i_enable (r_state == S_DRAW),
        .i_w      (r_w),
        .i_h      (r_h),
        .o_cx     (w_cx),
        .o_cy     (w_cy),
        .o_last   (w_last)
    );

    always_ff @(posedge clock) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept && !w_zero) w_next = S_DRAW;
            S_DRAW:  if (w_last) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_bx <= '0; r_by <= '0; r_w <= '0; r_h <= '0; r_col <= '0;
            r_vx <= '0; r_vy <= '0; r_vc <= '0; r_plot <= 1'b0; r_done <= 1'b0;
        end else begin
            r_plot <= 1'b0;
            r_done <= 1'b0;
            if (w_accept) begin
                r_col <= bus.req_colour;
                if (bus.req_clear) begin
                    r_bx <= '0;
                    r_by <= '0;
                    r_w  <= X_BITS'(SCREEN_W);
                    r_h  <= Y_BITS'(SCREEN_H);
                end else begin
                    r_bx <= bus.req_x;
                    r_by <= bus.req_y;
                    r_w  <= X_BITS'(bus.req_w);
                    r_h  <= Y_BITS'(bus.req_h);
                end
                if (w_zero) r_done <= 1'b1;
            end
            if (r_state == S_DRAW) begin
                r_plot <= w_inside;
                r_done <= w_last;
                // Clipped pixels leave the last visible write on the bus.
                if (w_inside) begin
                    r_vx <= w_px[X_BITS-1:0];
                    r_vy <= w_py[Y_BITS-1:0];
                    r_vc <= r_col;
                end
            end
        end
    end

    assign bus.req_ready  = (r_state == S_IDLE);
    assign bus.busy       = (r_state == S_DRAW);
    assign bus.vga_x      = r_vx;
    assign bus.vga_y      = r_vy;
    assign bus.vga_colour = r_vc;
    assign bus.vga_plot   = r_plot;
    assign bus.done       = r_done;
endmodule

// File: tb/tb_rect_draw_engine.sv
// Directed + random bench for rect_draw_engine against a per-pixel reference model.
module tb_rect_draw_engine;
    import draw_pkg::*;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   tests = 0;
    int   fails = 0;
    int   mx = 0, my = 0, mc = 0;   // model of last visible pixel write

    rect_draw_engine_if bus();

    rect_draw_engine dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, ".ready"}, 32'(bus.req_ready), 1);
        chk({tag, ".plot"},  32'(bus.vga_plot), 0);
        chk({tag, ".busy"},  32'(bus.busy), 0);
        chk({tag, ".done"},  32'(bus.done), 0);
    endtask

    // Drives one request and checks every cycle until it completes.
    task automatic run_req(input int x, input int y, input int w, input int h,
                           input int c, input bit clr, input string tag);
        int bx, by, bw, bh, px, py;
        bit vis, last;
        bx = clr ? 0 : x;  by = clr ? 0 : y;
        bw = clr ? SCREEN_W : w;  bh = clr ? SCREEN_H : h;
        chk({tag, ".ready0"}, 32'(bus.req_ready), 1);
        bus.req_valid  = 1'b1;
        bus.req_x      = 8'(x);
        bus.req_y      = 7'(y);
        bus.req_w      = 7'(w);
        bus.req_h      = 5'(h);
        bus.req_colour = 3'(c);
        bus.req_clear  = clr;
        tick();
        bus.req_valid = 1'b0;
        bus.req_x = '1; bus.req_y = '1; bus.req_w = '1; bus.req_h = '1; bus.req_colour = '1;
        if (bw == 0 || bh == 0) begin
            chk({tag, ".zdone"}, 32'(bus.done), 1);
            chk({tag, ".zplot"}, 32'(bus.vga_plot), 0);
            chk({tag, ".zbusy"}, 32'(bus.busy), 0);
            tick();
            chk_idle({tag, ".zafter"});
            return;
        end
        chk({tag, ".busy0"}, 32'(bus.busy), 1);
        chk({tag, ".plot0"}, 32'(bus.vga_plot), 0);
        for (int r = 0; r < bh; r++) begin
            for (int k = 0; k < bw; k++) begin
                tick();
                px = bx + k;  py = by + r;
                vis  = (px < SCREEN_W) && (py < SCREEN_H);
                last = (r == bh - 1) && (k == bw - 1);
                if (vis) begin mx = px; my = py; mc = c; end
                chk({tag, ".plot"},  32'(bus.vga_plot), 32'(vis));
                chk({tag, ".x"},     32'(bus.vga_x), 32'(mx));
                chk({tag, ".y"},     32'(bus.vga_y), 32'(my));
                chk({tag, ".col"},   32'(bus.vga_colour), 32'(mc));
                chk({tag, ".done"},  32'(bus.done), 32'(last));
                chk({tag, ".busy"},  32'(bus.busy), 32'(!last));
                chk({tag, ".ready"}, 32'(bus.req_ready), 32'(last));
            end
        end
    endtask

    initial begin
        bus.req_valid = 1'b0; bus.req_clear = 1'b0;
        bus.req_x = '0; bus.req_y = '0; bus.req_w = '0; bus.req_h = '0; bus.req_colour = '0;

        repeat (3) tick();
        chk_idle("rst");
        chk("rst.x", 32'(bus.vga_x), 0);
        chk("rst.y", 32'(bus.vga_y), 0);
        chk("rst.col", 32'(bus.vga_colour), 0);
        reset = 1'b0;
        tick();

        run_req(20, 60, 4, 2, 3'b110, 1'b0, "rect4x2");
        run_req(158, 118, 4, 4, int'(RED), 1'b0, "clip");
        run_req(30, 30, 0, 5, int'(GREEN), 1'b0, "zero");
        run_req(40, 40, 3, 0, int'(WHITE), 1'b0, "zeroh");
        run_req(200, 100, 50, 1, int'(WHITE), 1'b1, "clear");
        run_req(0, 0, 1, 1, int'(WHITE), 1'b0, "one");
        run_req(255, 127, 3, 2, int'(GREEN), 1'b0, "allclip");

        for (int i = 0; i < 12; i++)
            run_req($urandom_range(0, 175), $urandom_range(0, 127), $urandom_range(0, 12),
                    $urandom_range(0, 6), $urandom_range(0, 7), 1'b0, "rand");

        // Reset in the middle of a 4x2 draw abandons it without done.
        bus.req_valid = 1'b1; bus.req_clear = 1'b0;
        bus.req_x = 8'd50; bus.req_y = 7'd10; bus.req_w = 7'd4; bus.req_h = 5'd2;
        bus.req_colour = RED;
        tick();
        bus.req_valid = 1'b0;
        tick(); tick();
        chk("mid.x", 32'(bus.vga_x), 51);
        reset = 1'b1;
        tick();
        chk_idle("mid");
        chk("mid.vx", 32'(bus.vga_x), 0);
        reset = 1'b0;
        mx = 0; my = 0; mc = 0;
        tick();
        chk_idle("mid.after");
        run_req(5, 5, 1, 1, int'(GREEN), 1'b0, "post");

        // Reset beats a simultaneous request.
        reset = 1'b1; bus.req_valid = 1'b1;
        bus.req_w = 7'd3; bus.req_h = 5'd3; bus.req_clear = 1'b0;
        tick();
        reset = 1'b0; bus.req_valid = 1'b0;
        chk_idle("rstwin");
        tick();
        chk_idle("rstwin2");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/rect_draw_engine.md
Name: rect_draw_engine

Overview:
Pixel-write engine between the game datapath and vga_adapter (160x120, 3-bit colour). It accepts one rectangle request per valid/ready handshake and emits one clipped pixel write per clock (x, y, colour, plot), scanning row-major. The datapath uses it to erase and redraw the player and obstacle, and to clear the whole screen on game reset.

Parameters:
SCREEN_W, 160, visible width in pixels
SCREEN_H, 120, visible height in pixels
W_BITS, 7, width of req_w (max rect width 127)
H_BITS, 5, width of req_h (max rect height 31)

Ports:
clock  in  1  system clock (CLOCK_50)
reset  in  1  reset, synchronous, active-high
req_valid  in  1  request present; held with fields stable until accepted
req_ready  out  1  engine idle, can accept a request
req_x  in  8  rect top-left x
req_y  in  7  rect top-left y
req_w  in  W_BITS  rect width in pixels
req_h  in  H_BITS  rect height in pixels
req_colour  in  3  fill colour
req_clear  in  1  full-screen fill; ignores req_x/y/w/h
vga_x  out  8  pixel x to vga_adapter
vga_y  out  7  pixel y to vga_adapter
vga_colour  out  3  pixel colour
vga_plot  out  1  write strobe for the current pixel
busy  out  1  high while in DRAW
done  out  1  one-cycle pulse when a request completes

Behaviour:
- Reset values: state IDLE, req_ready=1, vga_x=0, vga_y=0, vga_colour=0, vga_plot=0, busy=0, done=0. Internal counters are cleared.
- States are IDLE and DRAW. req_ready = (state==IDLE), combinational from state.
- Accept happens at edge E0 when req_valid && req_ready:
  - latch x, y, w, h and colour;
  - if req_clear, use x=0, y=0, w=SCREEN_W, h=SCREEN_H;
  - zero counters cx (8b) and cy (7b).
- Zero-size request (w==0 or h==0, not clear):
  - state stays IDLE;
  - done=1 for the cycle after E0;
  - no plot is issued.
- Otherwise the state goes to DRAW at E0.
- DRAW:
  - each cycle computes px = base_x + cx (9b) and py = base_y + cy (8b);
  - at the next edge, registers vga_x=px[7:0], vga_y=py[6:0], vga_colour=colour;
  - vga_plot=1 iff px<SCREEN_W and py<SCREEN_H;
  - cx increments; at cx==w-1 it wraps to 0 and cy increments.
- Timing: pixel k (row-major) is on the vga_* outputs after edge E(k+1). A request occupies exactly w*h DRAW cycles, whether or not pixels are clipped.
- Last pixel (cx==w-1 && cy==h-1):
  - state returns to IDLE at the same edge the last pixel registers;
  - done=1 in that same cycle, alongside the final plot.
  - req_ready is high in that cycle, so the next request can be accepted at the following edge. The gap is one non-plotting cycle between requests.
- Clipped pixels:
  - vga_plot=0;
  - vga_x, vga_y and vga_colour hold their last values.
- IDLE: vga_plot=0; coordinates and colour hold.
- busy = (state==DRAW).
- Request fields are ignored while req_ready=0.
- Reset mid-DRAW: the draw is abandoned. Reset values apply at the next edge and no done is pulsed.
- Simultaneous reset and req_valid: reset wins and the request is not accepted.

Decomposition:
- Package draw_pkg holds:
  - SCREEN_W/SCREEN_H and the coordinate widths;
  - colour constants BLACK=3'b000, RED=3'b100, GREEN=3'b010, WHITE=3'b111;
  - the state encoding S_IDLE/S_DRAW.
- Sub-module rect_scan_counter: a 2-D counter with inputs start, w, h and enable. It outputs cx, cy and a combinational last flag. The engine keeps the FSM, the clip compare and the output registers.

Test Plan:
1. Reset held 3 cycles -> req_ready=1, vga_plot=0, busy=0, done=0, and vga_x/vga_y/vga_colour=0.
2. Request x=20, y=60, w=4, h=2, colour=3'b110 -> 8 consecutive plots starting 1 cycle after accept: (20,60)..(23,60) then (20,61)..(23,61). done coincides with (23,61); req_ready is high that cycle.
3. Request x=158, y=118, w=4, h=4 -> busy for 16 cycles with plot only at (158,118), (159,118), (158,119), (159,119). done on the 16th cycle.
4. Request w=0, h=5 -> no plot, busy stays 0, done pulses 1 cycle after accept.
5. req_clear=1 with colour=BLACK -> 19200 plots covering (0,0)..(159,119) row-major, last at (159,119) with done.
6. 4x2 draw with reset asserted during the 3rd pixel -> vga_plot=0 next cycle, no done, req_ready=1. A following 1x1 request at (5,5) plots exactly (5,5).
